// File: rtl/alu_seq_ctrl.sv
// Instruction sequencer for the 6-bit ALU: handshake, 4-entry register file, flag latching.
// Define ALU_SEQ_CTRL_WIDE_EN to compile in the chained two-pass 12-bit ALU12 instruction.
module alu_seq_ctrl #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [1:0]       instr_kind,
  input  logic [1:0]       instr_op,
  input  logic [1:0]       instr_rd,
  input  logic [1:0]       instr_rs,
  input  logic [WIDTH-1:0] instr_imm,
  input  logic             instr_cin,
  output logic             done,
  output logic             err,
  output logic             flag_cf,
  output logic             flag_sf,
  output logic             flag_zf,
  input  logic [1:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cf_prev,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_cf,
  input  logic             alu_sf,
  input  logic             alu_zf
);

  localparam logic [1:0] KIND_ALU = 2'b00;
  localparam logic [1:0] KIND_LDI = 2'b01;
  localparam logic [1:0] KIND_W12 = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_EXEC_LO = 2'b01,
`ifdef ALU_SEQ_CTRL_WIDE_EN
    S_EXEC_HI = 2'b10,
`endif
    S_DONE    = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_regs [4];
  logic [1:0]       r_kind;
  logic [1:0]       r_op;
  logic [1:0]       r_rd;
  logic [1:0]       r_rs;
  logic [WIDTH-1:0] r_imm;
  logic             r_cin;
  logic             r_cf;
  logic             r_sf;
  logic             r_zf;
  logic             r_ready;
  logic             r_done;
  logic             r_err;
  logic [1:0]       w_a_idx;
  logic [1:0]       w_b_idx;
  logic             w_lo_uses_alu;
  logic             w_illegal;
`ifdef ALU_SEQ_CTRL_WIDE_EN
  logic             r_tmp_cf;
  logic             r_zf_lo;

  assign w_lo_uses_alu = (r_kind == KIND_ALU) || (r_kind == KIND_W12);
  assign w_illegal     = (r_kind == 2'b11);
`else
  assign w_lo_uses_alu = (r_kind == KIND_ALU);
  assign w_illegal     = r_kind[1];
`endif

  // Operand selection and ALU drive; pair halves replace rd/rs during ALU12 passes.
  always_comb begin
    w_a_idx     = r_rd;
    w_b_idx     = r_rs;
    alu_a       = {WIDTH{1'b0}};
    alu_b       = {WIDTH{1'b0}};
    alu_op      = 2'b00;
    alu_cf_prev = 1'b0;
    case (r_state)
      S_EXEC_LO: begin
`ifdef ALU_SEQ_CTRL_WIDE_EN
        if (r_kind == KIND_W12) begin
          w_a_idx = {r_rd[1], 1'b0};
          w_b_idx = {r_rs[1], 1'b0};
        end else begin
          w_a_idx = r_rd;
          w_b_idx = r_rs;
        end
`endif
        if (w_lo_uses_alu) begin
          alu_a       = r_regs[w_a_idx];
          alu_b       = r_regs[w_b_idx];
          alu_op      = r_op;
          alu_cf_prev = r_cin & r_cf;
        end else begin
          alu_op      = 2'b00;
        end
      end
`ifdef ALU_SEQ_CTRL_WIDE_EN
      S_EXEC_HI: begin
        w_a_idx     = {r_rd[1], 1'b1};
        w_b_idx     = {r_rs[1], 1'b1};
        alu_a       = r_regs[w_a_idx];
        alu_b       = r_regs[w_b_idx];
        alu_op      = r_op;
        alu_cf_prev = r_tmp_cf;
      end
`endif
      default: begin
        alu_op = 2'b00;
      end
    endcase
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (instr_valid && r_ready) begin
          w_next = S_EXEC_LO;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_EXEC_LO: begin
`ifdef ALU_SEQ_CTRL_WIDE_EN
        if (r_kind == KIND_W12) begin
          w_next = S_EXEC_HI;
        end else begin
          w_next = S_DONE;
        end
`else
        w_next = S_DONE;
`endif
      end
`ifdef ALU_SEQ_CTRL_WIDE_EN
      S_EXEC_HI: w_next = S_DONE;
`endif
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // State register and handshake/retire outputs, registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_IDLE);
      r_done  <= (w_next == S_DONE);
      r_err   <= (w_next == S_DONE) && w_illegal;
    end
  end

  // Instruction latch, register file and flag updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_regs[i] <= {WIDTH{1'b0}};
      end
      r_kind <= 2'b00;
      r_op   <= 2'b00;
      r_rd   <= 2'b00;
      r_rs   <= 2'b00;
      r_imm  <= {WIDTH{1'b0}};
      r_cin  <= 1'b0;
      r_cf   <= 1'b0;
      r_sf   <= 1'b0;
      r_zf   <= 1'b0;
`ifdef ALU_SEQ_CTRL_WIDE_EN
      r_tmp_cf <= 1'b0;
      r_zf_lo  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (instr_valid && r_ready) begin
            r_kind <= instr_kind;
            r_op   <= instr_op;
            r_rd   <= instr_rd;
            r_rs   <= instr_rs;
            r_imm  <= instr_imm;
            r_cin  <= instr_cin;
          end
        end
        S_EXEC_LO: begin
          if (r_kind == KIND_ALU) begin
            r_regs[w_a_idx] <= alu_r;
            r_cf            <= alu_cf;
            r_sf            <= alu_sf;
            r_zf            <= alu_zf;
          end else if (r_kind == KIND_LDI) begin
            r_regs[r_rd] <= r_imm;
          end
`ifdef ALU_SEQ_CTRL_WIDE_EN
          else if (r_kind == KIND_W12) begin
            r_regs[w_a_idx] <= alu_r;
            r_tmp_cf        <= alu_cf;
            r_zf_lo         <= alu_zf;
          end
`endif
        end
`ifdef ALU_SEQ_CTRL_WIDE_EN
        S_EXEC_HI: begin
          r_regs[w_a_idx] <= alu_r;
          r_cf            <= alu_cf;
          r_sf            <= alu_sf;
          r_zf            <= r_zf_lo & alu_zf;
        end
`endif
        default: begin
          r_cf <= r_cf;
        end
      endcase
    end
  end

  assign instr_ready = r_ready;
  assign done        = r_done;
  assign err         = r_err;
  assign flag_cf     = r_cf;
  assign flag_sf     = r_sf;
  assign flag_zf     = r_zf;
  assign dbg_data    = r_regs[dbg_sel];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: transaction-level model predicts every cycle's outputs.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [1:0] instr_kind = 2'b00;
  logic [1:0] instr_op = 2'b00;
  logic [1:0] instr_rd = 2'b00;
  logic [1:0] instr_rs = 2'b00;
  logic [5:0] instr_imm = 6'h00;
  logic       instr_cin = 1'b0;
  logic       done, err, flag_cf, flag_sf, flag_zf;
  logic [1:0] dbg_sel = 2'b00;
  logic [5:0] dbg_data;
  logic [5:0] alu_a, alu_b, alu_r;
  logic       alu_cf_prev, alu_cf, alu_sf, alu_zf;
  logic [1:0] alu_op;
  logic [8:0] w_alu;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  bit cmp_en = 1'b0;
  bit m_ready_now = 1'b0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.WIDTH(6)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_kind(instr_kind), .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
    .instr_imm(instr_imm), .instr_cin(instr_cin),
    .done(done), .err(err), .flag_cf(flag_cf), .flag_sf(flag_sf), .flag_zf(flag_zf),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cf_prev(alu_cf_prev), .alu_op(alu_op),
    .alu_r(alu_r), .alu_cf(alu_cf), .alu_sf(alu_sf), .alu_zf(alu_zf)
  );

  // ALU stand-in: 00 AND, 01 ADD+cin, 10 SUB-cin (cf = borrow), 11 XOR. Returns {cf,sf,zf,r}.
  function automatic logic [8:0] alu_fn(input logic [5:0] a, input logic [5:0] b,
                                        input logic [1:0] op, input logic cin);
    int t;
    logic [5:0] r;
    logic c;
    case (op)
      2'b00:   begin r = a & b; c = 1'b0; end
      2'b01:   begin t = int'(a) + int'(b) + int'(cin); r = t[5:0]; c = (t > 63); end
      2'b10:   begin t = int'(a) - int'(b) - int'(cin); r = t[5:0]; c = (t < 0); end
      default: begin r = a ^ b; c = 1'b0; end
    endcase
    return {c, r[5], (r == 6'h00), r};
  endfunction

  assign w_alu  = alu_fn(alu_a, alu_b, alu_op, alu_cf_prev);
  assign alu_r  = w_alu[5:0];
  assign alu_zf = w_alu[6];
  assign alu_sf = w_alu[7];
  assign alu_cf = w_alu[8];

  typedef struct packed {
    logic            ready, done, err;
    logic [5:0]      a, b;
    logic [1:0]      op;
    logic            cfp, cf, sf, zf;
    logic [3:0][5:0] regs;
  } rec_t;

  // Architectural state and the per-cycle expected outputs still to come.
  logic [3:0][5:0] m_regs = '0;
  logic            m_cf = 1'b0, m_sf = 1'b0, m_zf = 1'b0;
  rec_t            exp_q[$];

  function automatic rec_t cur_rec();
    rec_t r;
    r      = '0;
    r.cf   = m_cf;
    r.sf   = m_sf;
    r.zf   = m_zf;
    r.regs = m_regs;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, exp);
    end
  endtask

  task automatic model_accept(input logic [1:0] k, input logic [1:0] op, input logic [1:0] rd,
                              input logic [1:0] rs, input logic [5:0] imm, input logic cin);
    rec_t r;
    logic [8:0] o;
    logic ill;
    logic zlo;
    ill = 1'b0;
    r = cur_rec();
    case (k)
      2'b00: begin
        r.a = m_regs[rd]; r.b = m_regs[rs]; r.op = op; r.cfp = cin & m_cf;
        exp_q.push_back(r);
        o = alu_fn(r.a, r.b, op, r.cfp);
        m_regs[rd] = o[5:0];
        {m_cf, m_sf, m_zf} = o[8:6];
      end
      2'b01: begin
        exp_q.push_back(r);
        m_regs[rd] = imm;
      end
`ifdef ALU_SEQ_CTRL_WIDE_EN
      2'b10: begin
        r.a = m_regs[{rd[1], 1'b0}]; r.b = m_regs[{rs[1], 1'b0}]; r.op = op; r.cfp = cin & m_cf;
        exp_q.push_back(r);
        o = alu_fn(r.a, r.b, op, r.cfp);
        m_regs[{rd[1], 1'b0}] = o[5:0];
        zlo = o[6];
        r = cur_rec();
        r.a = m_regs[{rd[1], 1'b1}]; r.b = m_regs[{rs[1], 1'b1}]; r.op = op; r.cfp = o[8];
        exp_q.push_back(r);
        o = alu_fn(r.a, r.b, op, r.cfp);
        m_regs[{rd[1], 1'b1}] = o[5:0];
        m_cf = o[8];
        m_sf = o[7];
        m_zf = zlo & o[6];
      end
`endif
      default: begin
        exp_q.push_back(r);
        ill = 1'b1;
      end
    endcase
    r = cur_rec();
    r.done = 1'b1;
    r.err = ill;
    exp_q.push_back(r);
  endtask

  logic       s_rst, s_acc, s_cin;
  logic [1:0] s_kind, s_op, s_rd, s_rs;
  logic [5:0] s_imm;

  // Model update at each active edge: reset, or accept when the model says the DUT is idle.
  always @(posedge clk) begin
    s_rst = rst;
    s_acc = instr_valid && m_ready_now && cmp_en;
    s_kind = instr_kind; s_op = instr_op; s_rd = instr_rd; s_rs = instr_rs;
    s_imm = instr_imm; s_cin = instr_cin;
    #1;
    if (s_rst) begin
      exp_q.delete();
      m_regs = '0;
      m_cf = 1'b0; m_sf = 1'b0; m_zf = 1'b0;
    end else if (s_acc) begin
      model_accept(s_kind, s_op, s_rd, s_rs, s_imm, s_cin);
      acc_cnt++;
    end
  end

  rec_t e;
  // Compare every DUT output against the model each cycle, on the inactive edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end else begin
        e = cur_rec();
        e.ready = 1'b1;
      end
      m_ready_now = e.ready;
      chk("instr_ready", {5'b0, instr_ready}, {5'b0, e.ready});
      chk("done", {5'b0, done}, {5'b0, e.done});
      chk("err", {5'b0, err}, {5'b0, e.err});
      chk("alu_a", alu_a, e.a);
      chk("alu_b", alu_b, e.b);
      chk("alu_op", {4'b0, alu_op}, {4'b0, e.op});
      chk("alu_cf_prev", {5'b0, alu_cf_prev}, {5'b0, e.cfp});
      chk("flags", {3'b0, flag_cf, flag_sf, flag_zf}, {3'b0, e.cf, e.sf, e.zf});
      for (int s = 0; s < 4; s++) begin
        dbg_sel = 2'(s);
        #1;
        chk("dbg_data", dbg_data, e.regs[s]);
      end
    end
  end

  task automatic issue(input logic [1:0] k, input logic [1:0] op, input logic [1:0] rd,
                       input logic [1:0] rs, input logic [5:0] imm, input logic cin);
    int start;
    bit got;
    start = acc_cnt;
    got = 1'b0;
    instr_kind = k; instr_op = op; instr_rd = rd; instr_rs = rs;
    instr_imm = imm; instr_cin = cin; instr_valid = 1'b1;
    for (int n = 0; n < 12 && !got; n++) begin
      @(posedge clk); #2;
      if (acc_cnt != start) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: instruction not accepted within 12 cycles");
    end
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic pulse_rst();
    instr_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    chk("reset_ready", {5'b0, instr_ready}, 6'h01);
    chk("reset_flags", {3'b0, flag_cf, flag_sf, flag_zf}, 6'h00);

    issue(2'b01, 2'b00, 2'd2, 2'd0, 6'h15, 1'b0); idle(3);
    chk("ldi_r2_model", m_regs[2], 6'h15);
    chk("ldi_flags", {3'b0, flag_cf, flag_sf, flag_zf}, 6'h00);

    issue(2'b01, 2'b00, 2'd0, 2'd0, 6'h3F, 1'b0);
    issue(2'b01, 2'b00, 2'd1, 2'd0, 6'h01, 1'b0);
    issue(2'b00, 2'b01, 2'd0, 2'd1, 6'h00, 1'b0); idle(3);
    chk("alu_r0_model", m_regs[0], 6'h00);
    chk("alu_flags", {3'b0, flag_cf, flag_sf, flag_zf}, 6'b000_101);

    issue(2'b00, 2'b01, 2'd3, 2'd3, 6'h00, 1'b1); idle(3);
    chk("cin1_r3_model", m_regs[3], 6'h01);
    issue(2'b01, 2'b00, 2'd0, 2'd0, 6'h3F, 1'b0);
    issue(2'b00, 2'b01, 2'd0, 2'd1, 6'h00, 1'b0);
    issue(2'b00, 2'b01, 2'd3, 2'd3, 6'h00, 1'b0); idle(3);
    chk("cin0_r3_model", m_regs[3], 6'h02);

    issue(2'b01, 2'b00, 2'd0, 2'd0, 6'h3F, 1'b0);
    issue(2'b01, 2'b00, 2'd1, 2'd0, 6'h00, 1'b0);
    issue(2'b01, 2'b00, 2'd2, 2'd0, 6'h01, 1'b0);
    issue(2'b01, 2'b00, 2'd3, 2'd0, 6'h00, 1'b0);
    issue(2'b10, 2'b01, 2'd0, 2'd2, 6'h00, 1'b0); idle(4);
`ifdef ALU_SEQ_CTRL_WIDE_EN
    chk("alu12_lo_model", m_regs[0], 6'h00);
    chk("alu12_hi_model", m_regs[1], 6'h01);
`else
    chk("kind10_lo_model", m_regs[0], 6'h3F);
    chk("kind10_hi_model", m_regs[1], 6'h00);
`endif
    chk("alu12_flags", {3'b0, flag_cf, flag_sf, flag_zf}, 6'h00);

    issue(2'b11, 2'b01, 2'd0, 2'd2, 6'h00, 1'b1); idle(3);
    chk("illegal_r2_model", m_regs[2], 6'h01);

    issue(2'b01, 2'b00, 2'd1, 2'd0, 6'h05, 1'b0);
    issue(2'b01, 2'b00, 2'd0, 2'd0, 6'h07, 1'b0);
    issue(2'b00, 2'b01, 2'd0, 2'd1, 6'h00, 1'b0);
    pulse_rst(); idle(3);
    chk("midrst_r0_model", m_regs[0], 6'h00);
    chk("midrst_ready", {5'b0, instr_ready}, 6'h01);

    for (int i = 0; i < 300; i++) begin
      issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 39) == 0) begin
        pulse_rst();
      end else if ($urandom_range(0, 2) == 0) begin
        idle($urandom_range(1, 3));
      end
    end
    idle(6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

- Sequences the 6-bit ALU (`alu_6_bit`) for the CPU datapath.
- Accepts one instruction per valid/ready handshake and reads operands from a 4-entry register file.
- Drives the ALU and writes back the result and flags.
- Optionally chains two ALU passes to run a 12-bit operation on register pairs, passing the low-pass carry into the high pass through `cf_prev`.

## Interface
- WIDTH, 6, datapath width; must match the ALU.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  controller idle, can accept.
- instr_kind  in  2  00 ALU, 01 LDI, 10 ALU12, 11 illegal.
- instr_op  in  2  ALU opcode, passed unchanged to alu_op.
- instr_rd  in  2  destination register (also operand A).
- instr_rs  in  2  source register (operand B).
- instr_imm  in  WIDTH  immediate for LDI.
- instr_cin  in  1  1: first pass uses latched flag_cf as carry-in; 0: carry-in 0.
- done  out  1  one-cycle pulse when an instruction retires.
- err  out  1  one-cycle pulse, coincident with done, for an illegal instruction.
- flag_cf / flag_sf / flag_zf  out  1 each  latched flags.
- dbg_sel  in  2  register to observe.
- dbg_data  out  WIDTH  combinational read of R[dbg_sel].
- alu_a, alu_b  out  WIDTH  ALU operands.
- alu_cf_prev  out  1  ALU carry-in.
- alu_op  out  2  ALU opcode.
- alu_r  in  WIDTH  ALU result.
- alu_cf, alu_sf, alu_zf  in  1 each  ALU flags.

## Operation
- State: registers R0..R3, flags CF/SF/ZF, latched instruction fields.
- FSM: IDLE → EXEC_LO → (EXEC_HI if ALU12) → DONE → IDLE.
- **IDLE:** instr_ready=1. The instruction is latched when instr_valid & instr_ready.
- **EXEC_LO, ALU:** drives alu_a=R[rd], alu_b=R[rs], alu_op=op, alu_cf_prev=cin?CF:0. At the end of the cycle, writes R[rd]←alu_r and CF/SF/ZF←alu flags.
- **EXEC_LO, LDI:** R[rd]←imm; flags unchanged; ALU outputs driven 0.
- **EXEC_LO, illegal (11):** no register or flag change; err is set for the DONE cycle.
- **ALU12, low half:** uses registers {rd[1],0} (low) and {rd[1],1} (high); same for rs.
  - EXEC_LO operates on the low registers and writes the low destination.
  - The ALU carry is held in an internal temp register; flags are not updated.
- **ALU12, high half:** EXEC_HI operates on the high registers with alu_cf_prev = temp carry and writes the high destination.
  - CF←alu_cf and SF←alu_sf.
  - ZF←(zf_lo & alu_zf), where zf_lo is latched from EXEC_LO.
- **DONE:** done=1; err=1 only for an illegal instruction. instr_ready=0.
- Outside EXEC states, alu_a, alu_b, alu_op and alu_cf_prev are driven 0.
- Source and destination may be the same register; operands are read combinationally before the clock edge that writes.

## Timing
- **Reset values:** instr_ready=1, done=0, err=0, all flags 0, R0..R3=0, ALU outputs 0, FSM in IDLE.
- **Latency** (accept edge at T):
  - ALU/LDI/illegal: EXEC_LO in cycle T+1; done in cycle T+2; ready again in T+3.
  - ALU12: EXEC_LO in T+1, EXEC_HI in T+2, done in T+3.
- instr_valid is ignored while instr_ready=0; the upstream holds the instruction.
- **Reset mid-operation:** aborts the instruction with no done pulse. All state clears, including a low half already written.
- flag_* change only on the edge ending the final EXEC cycle of ALU/ALU12.
- dbg_data reflects the write on the cycle after the write edge.

## Configuration
- **`ALU_SEQ_CTRL_WIDE_EN` defined:** ALU12 and the EXEC_HI state are compiled in.
- **Undefined:** kind 10 is treated exactly as illegal (err pulse, no state change, 2-cycle retire). No EXEC_HI state or temp carry/zf registers exist.

## Test plan
- **Reset:** after rst, instr_ready=1, flags 0, dbg_data=0 for all dbg_sel; assert rst during EXEC_LO of an ALU instruction → no done pulse and R[rd] stays 0.
- **LDI:** LDI R2←6'h15 → dbg_sel=2 reads 6'h15 in T+2, done at T+2, flags unchanged.
- **ALU:** LDI R0←6'h3F and R1←6'h01, then ALU op=01 rd=0 rs=1 cin=0 → in T+1 alu_a=6'h3F, alu_b=6'h01, alu_cf_prev=0; R0 and flags equal the `alu_6_bit` outputs from that cycle.
- **Carry-in:** with CF=1, issue ALU cin=1 → alu_cf_prev=1 in EXEC_LO; repeat with cin=0 → alu_cf_prev=0.
- **ALU12 (macro on):** R0=6'h3F, R1=6'h00, R2=6'h01, R3=6'h00, ALU12 rd=0 rs=2 op=01.
  - EXEC_HI has alu_cf_prev equal to the low-pass alu_cf.
  - done at T+3; ZF is the AND of both zf values.
- **ALU12 (macro off) / illegal:** kind 10 (macro off) or kind 11 → err=done=1 at T+2, registers and flags unchanged; instr_valid held high during busy → exactly one accept.
